// File: rtl/pll_reset_sequencer.sv
// Purpose: sequence PLL reset, wait for stable lock, then release the core reset; retry or fail on timeout.
// Latency: pll_locked passes a 2-flop synchronizer; all outputs are registered and move with the state register.
// Backpressure: none; relock_req is a single-cycle request honoured on the next refclk edge.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE      = 16,
    parameter int unsigned LOCK_TIMEOUT   = 50000,
    parameter int unsigned LOCK_STABLE    = 1024,
    parameter int unsigned POST_LOCK_HOLD = 64,
    parameter int unsigned MAX_RETRY      = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       lock_err,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_e;

    // Terminal counter values: a state of duration N exits when the counter reads N-1.
    localparam logic [19:0] RST_LAST     = 20'(RST_PULSE - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] STABLE_LAST  = 20'(LOCK_STABLE - 1);
    localparam logic [19:0] HOLD_LAST    = 20'(POST_LOCK_HOLD - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        sync_meta_q, locked_s_q;
    logic        pll_rst_q, pll_rst_d;
    logic        sys_reset_n_q, sys_reset_n_d;
    logic        ready_q, ready_d;
    logic        lock_err_q, lock_err_d;

    // Bring the asynchronous lock indicator into the refclk domain.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            sync_meta_q <= pll_locked;
            locked_s_q  <= sync_meta_q;
        end
    end

    // Next-state, counter, retry and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 20'd1;
        retry_d = retry_q;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q >= RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_RESET_PLL;
                        retry_d = retry_q + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                // Lock loss wins over the end of the stability window.
                if (!locked_s_q)                state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!locked_s_q)                state_d = S_RESET_PLL;
                else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    retry_d = 4'd0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s_q) state_d = S_RESET_PLL;
            end
            S_FAIL: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        // Every state entry starts the counter from zero.
        if (state_d != state_q) cnt_d = 20'd0;

        // A relock request restarts the whole sequence, even mid-pulse.
        if (relock_req) begin
            state_d = S_RESET_PLL;
            cnt_d   = 20'd0;
            retry_d = 4'd0;
        end

        pll_rst_d     = (state_d == S_RESET_PLL);
        sys_reset_n_d = (state_d == S_RUN);
        ready_d       = (state_d == S_RUN);
        lock_err_d    = (state_d == S_FAIL);
    end

    // State, counter and output registers share one edge so outputs track the state exactly.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESET_PLL;
            cnt_q         <= 20'd0;
            retry_q       <= 4'd0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            lock_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            lock_err_q    <= lock_err_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign lock_err    = lock_err_q;
    assign retry_cnt   = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: directed checks of the PLL reset sequencer with short timing parameters.
// Latency: outputs sampled 1 ns after each rising refclk edge.
// Backpressure: none; stimulus is a fixed linear script.
module tb_pll_reset_sequencer;

    localparam logic [2:0] ST_RST  = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_STB  = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_FAIL = 3'd5;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       lock_err;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pll_reset_sequencer #(
        .RST_PULSE     (4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (8),
        .POST_LOCK_HOLD(5),
        .MAX_RETRY     (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .lock_err   (lock_err),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Expected output vector {state, pll_rst, sys_reset_n, ready, lock_err, retry_cnt}.
    function automatic logic [10:0] ev(input logic [2:0] st, input logic p, input logic s,
                                       input logic r, input logic e, input logic [3:0] rc);
        return {st, p, s, r, e, rc};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [10:0] exp);
        chk(tag, {state, pll_rst, sys_reset_n, ready, lock_err, retry_cnt}, exp);
    endtask

    // Advance n rising edges, then step 1 ns past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(2);
        chk_out("reset_values", ev(ST_RST, 1, 0, 0, 0, 4'd0));

        // Normal lock: pll_rst held 4 edges after release.
        rst_n = 1'b1;
        tick(3);
        chk_out("pulse_edge3", ev(ST_RST, 1, 0, 0, 0, 4'd0));
        tick(1);
        chk_out("pulse_end", ev(ST_WAIT, 0, 0, 0, 0, 4'd0));
        tick(3);
        pll_locked = 1'b1;                     // first sampled at the next edge (g1)
        tick(2);
        chk_out("sync_latency", ev(ST_WAIT, 0, 0, 0, 0, 4'd0));
        tick(1);
        chk_out("enter_stable", ev(ST_STB, 0, 0, 0, 0, 4'd0));
        tick(8);
        chk_out("enter_hold", ev(ST_HOLD, 0, 0, 0, 0, 4'd0));
        tick(4);
        chk_out("hold_last", ev(ST_HOLD, 0, 0, 0, 0, 4'd0));
        tick(1);                               // 15 edges after g1
        chk_out("enter_run", ev(ST_RUN, 0, 1, 1, 0, 4'd0));

        // Lock loss in RUN: seen two edges after the first sampling edge.
        pll_locked = 1'b0;
        tick(2);
        chk_out("run_before_loss", ev(ST_RUN, 0, 1, 1, 0, 4'd0));
        tick(1);
        chk_out("run_loss", ev(ST_RST, 1, 0, 0, 0, 4'd0));
        tick(3);
        chk_out("relock_pulse_edge3", ev(ST_RST, 1, 0, 0, 0, 4'd0));
        tick(1);
        chk_out("relock_pulse_end", ev(ST_WAIT, 0, 0, 0, 0, 4'd0));

        // Glitch in STABLE at count 5; the loss lands on the last STABLE count.
        pll_locked = 1'b1;
        tick(3);
        chk_out("glitch_pre_stable", ev(ST_STB, 0, 0, 0, 0, 4'd0));
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;                     // glitch end first sampled at next edge
        tick(2);
        chk_out("glitch_back_wait", ev(ST_WAIT, 0, 0, 0, 0, 4'd0));
        tick(1);
        chk_out("glitch_restable", ev(ST_STB, 0, 0, 0, 0, 4'd0));
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("glitch_srn_low", {10'd0, sys_reset_n}, 11'd0);
        end
        chk_out("glitch_hold", ev(ST_HOLD, 0, 0, 0, 0, 4'd0));
        tick(1);
        chk_out("glitch_run", ev(ST_RUN, 0, 1, 1, 0, 4'd0));

        // relock_req in RUN.
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        chk_out("relock_in_run", ev(ST_RST, 1, 0, 0, 0, 4'd0));
        tick(4);
        chk_out("relock_run_wait", ev(ST_WAIT, 0, 0, 0, 0, 4'd0));
        tick(1);
        chk_out("relock_run_stable", ev(ST_STB, 0, 0, 0, 0, 4'd0));
        tick(8);
        chk_out("reach_hold", ev(ST_HOLD, 0, 0, 0, 0, 4'd0));

        // Async reset between edges during HOLD.
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset_hold", ev(ST_RST, 1, 0, 0, 0, 4'd0));
        pll_locked = 1'b0;
        tick(2);

        // Never lock: three attempts of 24 edges, FAIL at edge 72.
        rst_n = 1'b1;
        tick(4);
        chk_out("nl_wait1", ev(ST_WAIT, 0, 0, 0, 0, 4'd0));
        tick(20);
        chk_out("nl_pulse2", ev(ST_RST, 1, 0, 0, 0, 4'd1));
        tick(4);
        chk_out("nl_wait2", ev(ST_WAIT, 0, 0, 0, 0, 4'd1));
        tick(20);
        chk_out("nl_pulse3", ev(ST_RST, 1, 0, 0, 0, 4'd2));
        tick(4);
        chk_out("nl_wait3", ev(ST_WAIT, 0, 0, 0, 0, 4'd2));
        tick(19);
        chk_out("nl_before_fail", ev(ST_WAIT, 0, 0, 0, 0, 4'd2));
        tick(1);
        chk_out("nl_fail", ev(ST_FAIL, 0, 0, 0, 1, 4'd2));
        tick(10);
        chk_out("fail_sticky", ev(ST_FAIL, 0, 0, 0, 1, 4'd2));

        // relock_req in FAIL, then again mid-pulse to restart the pulse.
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        chk_out("relock_in_fail", ev(ST_RST, 1, 0, 0, 0, 4'd0));
        tick(2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        chk_out("relock_in_pulse", ev(ST_RST, 1, 0, 0, 0, 4'd0));
        tick(3);
        chk_out("restart_pulse_edge3", ev(ST_RST, 1, 0, 0, 0, 4'd0));
        tick(1);
        chk_out("restart_pulse_end", ev(ST_WAIT, 0, 0, 0, 0, 4'd0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
